// File: rtl/dm_arbiter_if.sv
// Requester-side command/response bundle for dm_arbiter.
// master: the requester (drives the command, receives ready and the response).
// slave:  the arbiter (accepts the command, returns ready and the response).
interface dm_arbiter_if #(
  parameter int unsigned ADDRESS_LINE = 8,
  parameter int unsigned DATA_W       = 8
);
  logic                    valid;
  logic                    ready;
  logic                    we;
  logic [ADDRESS_LINE-1:0] addr;
  logic [DATA_W-1:0]       wdata;
  logic                    rsp_valid;
  logic [DATA_W-1:0]       rsp_rdata;

  modport master (
    output valid, we, addr, wdata,
    input  ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  valid, we, addr, wdata,
    output ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/dm_arbiter.sv
// Two-requester arbiter/sequencer for the single-port 8-bit data memory.
// Each accepted command takes one ACCESS cycle on the memory pins followed by a
// one-cycle response to the requester that won, so at most one transaction per 3 cycles.
// Ties go round-robin by default; define DM_ARB_FIXED_PRIO_EN to make r0 always win a tie.
module dm_arbiter #(
  parameter int unsigned ADDRESS_LINE = 8,
  parameter int unsigned DATA_W       = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  dm_arbiter_if.slave             r0,
  dm_arbiter_if.slave             r1,
  output logic [ADDRESS_LINE-1:0] mem_address,
  output logic [DATA_W-1:0]       mem_write_data,
  output logic                    mem_write,
  output logic                    mem_read,
  input  logic [DATA_W-1:0]       mem_read_data,
  output logic                    busy,
  output logic                    grant_id
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e                  state_q;
  logic                    grant_q;
  logic                    we_q;
  logic [ADDRESS_LINE-1:0] addr_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [DATA_W-1:0]       rdata_q;
  logic                    mem_write_q;
  logic                    mem_read_q;
  logic                    busy_q;
  logic                    rsp0_q;
  logic                    rsp1_q;
`ifndef DM_ARB_FIXED_PRIO_EN
  logic                    last_grant_q;
`endif

  logic                    win;
  logic                    accept;
  logic                    sel_we;
  logic [ADDRESS_LINE-1:0] sel_addr;
  logic [DATA_W-1:0]       sel_wdata;

  // Winner selection and same-cycle ready; ready is held low while reset is asserted.
  always_comb begin
    win = 1'b0;
`ifdef DM_ARB_FIXED_PRIO_EN
    win = ~r0.valid;
`else
    if (r0.valid && r1.valid) begin
      win = ~last_grant_q;
    end else begin
      win = ~r0.valid;
    end
`endif
    accept    = (state_q == StIdle) && reset && (r0.valid || r1.valid);
    r0.ready  = accept & r0.valid & ~win;
    r1.ready  = accept & r1.valid & win;
    sel_we    = win ? r1.we    : r0.we;
    sel_addr  = win ? r1.addr  : r0.addr;
    sel_wdata = win ? r1.wdata : r0.wdata;
  end

  // Sequencer FSM with registered memory strobes and response flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      grant_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      busy_q      <= 1'b0;
      rsp0_q      <= 1'b0;
      rsp1_q      <= 1'b0;
`ifndef DM_ARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q     <= StAccess;
            busy_q      <= 1'b1;
            grant_q     <= win;
            we_q        <= sel_we;
            addr_q      <= sel_addr;
            wdata_q     <= sel_wdata;
            mem_write_q <= sel_we;
            mem_read_q  <= ~sel_we;
`ifndef DM_ARB_FIXED_PRIO_EN
            last_grant_q <= win;
`endif
          end
        end
        StAccess: begin
          state_q     <= StResp;
          mem_write_q <= 1'b0;
          mem_read_q  <= 1'b0;
          // Writes report zero data, so clear the capture register for them.
          rdata_q     <= we_q ? '0 : mem_read_data;
          rsp0_q      <= ~grant_q;
          rsp1_q      <= grant_q;
        end
        StResp: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          rsp0_q  <= 1'b0;
          rsp1_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // The latched address/data only change on a handshake, so they hold outside ACCESS.
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_write      = mem_write_q;
  assign mem_read       = mem_read_q;
  assign busy           = busy_q;
  assign grant_id       = grant_q;

  assign r0.rsp_valid = rsp0_q;
  assign r1.rsp_valid = rsp1_q;
  assign r0.rsp_rdata = rsp0_q ? rdata_q : '0;
  assign r1.rsp_rdata = rsp1_q ? rdata_q : '0;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios with literal expectations, then randomized
// traffic, all checked every cycle against a transaction-level model.
module tb_dm_arbiter;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  logic          clk;
  logic          reset;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data;
  logic [DW-1:0] mem_read_data;
  logic          mem_write;
  logic          mem_read;
  logic          busy;
  logic          grant_id;

  dm_arbiter_if #(.ADDRESS_LINE(AW), .DATA_W(DW)) bus0 ();
  dm_arbiter_if #(.ADDRESS_LINE(AW), .DATA_W(DW)) bus1 ();

  dm_arbiter #(.ADDRESS_LINE(AW), .DATA_W(DW)) dut (
    .clk            (clk),
    .reset          (reset),
    .r0             (bus0),
    .r1             (bus1),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_read_data  (mem_read_data),
    .busy           (busy),
    .grant_id       (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory seen by the DUT; unwritten locations read as addr ^ 0x5A.
  logic [7:0] env_mem [256];
  bit         env_wr  [256];
  always @(posedge clk) begin
    if (mem_write) begin
      env_mem[mem_address] <= mem_write_data;
      env_wr[mem_address]  <= 1'b1;
    end
  end
  assign mem_read_data = env_wr[mem_address] ? env_mem[mem_address] : (mem_address ^ 8'h5A);

  // Transaction-level model: slot 0 = free, 1 = memory access due, 2 = response due.
  int         m_slot;
  bit         m_last;
  bit         m_who;
  bit         m_we;
  logic [7:0] m_addr;
  logic [7:0] m_wdata;
  logic [7:0] m_rdata;
  logic [7:0] ref_mem [256];
  bit         hs0;
  bit         hs1;
  int         n_vec;
  int         n_bad;

  task automatic model_reset();
    m_slot  = 0;
    m_last  = 1'b1;
    m_who   = 1'b0;
    m_we    = 1'b0;
    m_addr  = 8'h00;
    m_wdata = 8'h00;
    m_rdata = 8'h00;
  endtask

  function automatic bit pick(input bit v0, input bit v1);
`ifdef DM_ARB_FIXED_PRIO_EN
    return !v0;
`else
    if (v0 && v1) return !m_last;
    return !v0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Compare all outputs against the model at the falling edge, then advance the model.
  task automatic sample();
    bit v0, v1, win, e0, e1, rv0, rv1;
    @(negedge clk);
    if (!reset) model_reset();
    v0  = bus0.valid;
    v1  = bus1.valid;
    win = pick(v0, v1);
    e0  = reset && (m_slot == 0) && v0 && !win;
    e1  = reset && (m_slot == 0) && v1 && win;
    rv0 = (m_slot == 2) && !m_who;
    rv1 = (m_slot == 2) && m_who;
    chk("r0_ready", 32'(bus0.ready), 32'(e0));
    chk("r1_ready", 32'(bus1.ready), 32'(e1));
    chk("busy", 32'(busy), 32'(m_slot != 0));
    chk("grant_id", 32'(grant_id), 32'(m_who));
    chk("mem_address", 32'(mem_address), 32'(m_addr));
    chk("mem_write_data", 32'(mem_write_data), 32'(m_wdata));
    chk("mem_write", 32'(mem_write), 32'((m_slot == 1) && m_we));
    chk("mem_read", 32'(mem_read), 32'((m_slot == 1) && !m_we));
    chk("r0_rsp_valid", 32'(bus0.rsp_valid), 32'(rv0));
    chk("r1_rsp_valid", 32'(bus1.rsp_valid), 32'(rv1));
    chk("r0_rsp_rdata", 32'(bus0.rsp_rdata), rv0 ? 32'(m_rdata) : 32'd0);
    chk("r1_rsp_rdata", 32'(bus1.rsp_rdata), rv1 ? 32'(m_rdata) : 32'd0);
    hs0 = v0 && e0;
    hs1 = v1 && e1;
    if (reset) begin
      case (m_slot)
        0: begin
          if (hs0 || hs1) begin
            m_who   = win;
            m_last  = win;
            m_we    = win ? bus1.we : bus0.we;
            m_addr  = win ? bus1.addr : bus0.addr;
            m_wdata = win ? bus1.wdata : bus0.wdata;
            m_slot  = 1;
          end
        end
        1: begin
          m_rdata = m_we ? 8'h00 : ref_mem[m_addr];
          if (m_we) ref_mem[m_addr] = m_wdata;
          m_slot = 2;
        end
        default: m_slot = 0;
      endcase
    end
  endtask

  task automatic drive(input bit v0, input bit w0, input logic [7:0] a0, input logic [7:0] d0,
                       input bit v1, input bit w1, input logic [7:0] a1, input logic [7:0] d1);
    @(posedge clk);
    #1;
    bus0.valid = v0; bus0.we = w0; bus0.addr = a0; bus0.wdata = d0;
    bus1.valid = v1; bus1.we = w1; bus1.addr = a1; bus1.wdata = d1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic do_reset();
    bus0.valid = 1'b0;
    bus1.valid = 1'b0;
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
  endtask

  initial begin
    bit         p0, p1;
    bit         exp0, exp1;
    n_vec = 0;
    n_bad = 0;
    hs0   = 1'b0;
    hs1   = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
    bus0.valid = 1'b0; bus0.we = 1'b0; bus0.addr = '0; bus0.wdata = '0;
    bus1.valid = 1'b0; bus1.we = 1'b0; bus1.addr = '0; bus1.wdata = '0;
    reset = 1'b0;
    model_reset();
    #2;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset mem_write", 32'(mem_write), 32'd0);
    chk("reset grant_id", 32'(grant_id), 32'd0);
    chk("reset mem_address", 32'(mem_address), 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;

    // r0 writes 0xA5 to 0x10.
    drive(1'b1, 1'b1, 8'h10, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00);
    sample();
    chk("t1 r0_ready", 32'(bus0.ready), 32'd1);
    idle(); sample();
    chk("t1 mem_write", 32'(mem_write), 32'd1);
    chk("t1 mem_address", 32'(mem_address), 32'h10);
    chk("t1 mem_write_data", 32'(mem_write_data), 32'hA5);
    idle(); sample();
    chk("t1 r0_rsp_valid", 32'(bus0.rsp_valid), 32'd1);
    chk("t1 r0_rsp_rdata", 32'(bus0.rsp_rdata), 32'h00);

    // r1 reads 0x10 back.
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
    sample();
    chk("t2 r1_ready", 32'(bus1.ready), 32'd1);
    idle(); sample();
    chk("t2 mem_read", 32'(mem_read), 32'd1);
    idle(); sample();
    chk("t2 r1_rsp_valid", 32'(bus1.rsp_valid), 32'd1);
    chk("t2 r1_rsp_rdata", 32'(bus1.rsp_rdata), 32'hA5);
    chk("t2 r0_rsp_valid", 32'(bus0.rsp_valid), 32'd0);

    // Both requesters hold valid from reset.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, 1'b0, 8'h30, 8'h00, 1'b1, 1'b0, 8'h31, 8'h00);
      sample();
`ifdef DM_ARB_FIXED_PRIO_EN
      exp0 = (k % 3) == 0;
      exp1 = 1'b0;
`else
      exp0 = (k % 6) == 0;
      exp1 = (k % 6) == 3;
`endif
      chk("t3 r0_ready", 32'(bus0.ready), 32'(exp0));
      chk("t3 r1_ready", 32'(bus1.ready), 32'(exp1));
      chk("t3 busy", 32'(busy), 32'((k % 3) != 0));
    end

    // Reset during a write's ACCESS cycle aborts it.
    do_reset();
    drive(1'b1, 1'b1, 8'h20, 8'h3C, 1'b0, 1'b0, 8'h00, 8'h00);
    sample();
    chk("t4 r0_ready", 32'(bus0.ready), 32'd1);
    idle();
    #1;
    chk("t4 mem_write before reset", 32'(mem_write), 32'd1);
    reset = 1'b0;
    model_reset();
    #1;
    chk("t4 mem_write after reset", 32'(mem_write), 32'd0);
    chk("t4 busy after reset", 32'(busy), 32'd0);
    sample();
    @(posedge clk);
    #1 reset = 1'b1;
    idle(); sample();
    chk("t4 no r0_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
    drive(1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b0, 8'h21, 8'h00);
    sample();
    chk("t4 tie r0_ready", 32'(bus0.ready), 32'd1);
    chk("t4 tie r1_ready", 32'(bus1.ready), 32'd0);
    idle(); sample();
    idle(); sample();
    chk("t4 aborted write left data", 32'(bus0.rsp_rdata), 32'h7A);

    // r1 alone streams reads of 0x00, 0x01, 0x02.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'(i), 8'h00);
      sample();
      chk("t5 r1_ready", 32'(bus1.ready), 32'd1);
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'(i + 1), 8'h00);
      sample();
      chk("t5 mem_address", 32'(mem_address), 32'(i));
      chk("t5 mem_read", 32'(mem_read), 32'd1);
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'(i + 1), 8'h00);
      sample();
      chk("t5 r1_rsp_rdata", 32'(bus1.rsp_rdata), 32'(8'(i) ^ 8'h5A));
    end

    // Randomized traffic with occasional dropped valids and mid-cycle resets.
    idle(); sample();
    idle(); sample();
    p0 = 1'b0;
    p1 = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      reset = 1'b1;
      if (hs0) p0 = 1'b0;
      if (hs1) p1 = 1'b0;
      if (p0 && $urandom_range(0, 19) == 0) p0 = 1'b0;
      if (p1 && $urandom_range(0, 19) == 0) p1 = 1'b0;
      if (!p0 && $urandom_range(0, 1) == 1) begin
        p0 = 1'b1;
        bus0.we    = 1'($urandom_range(0, 1));
        bus0.addr  = 8'($urandom_range(0, 7));
        bus0.wdata = 8'($urandom);
      end
      if (!p1 && $urandom_range(0, 1) == 1) begin
        p1 = 1'b1;
        bus1.we    = 1'($urandom_range(0, 1));
        bus1.addr  = 8'($urandom_range(0, 7));
        bus1.wdata = 8'($urandom);
      end
      bus0.valid = p0;
      bus1.valid = p1;
      if ($urandom_range(0, 299) == 0) begin
        #2;
        reset = 1'b0;
        model_reset();
        p0 = 1'b0;
        p1 = 1'b0;
        bus0.valid = 1'b0;
        bus1.valid = 1'b0;
      end
      sample();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
